// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker pair: sync states and the
// default 16-bit tap mask (bit 0 is the leftmost literal bit).
package prbs_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } sync_state_e;

  localparam logic [0:15] PRBS_TAPS_16 = 16'b0110100000000001;

endpackage

// File: rtl/prbs_loss_monitor.sv
// Windowed error monitor: emits a combinational loss pulse on the sample that
// brings the window error count to LOSS_THR; counters restart per window.
module prbs_loss_monitor #(
  parameter int LOSS_WIN = 64,
  parameter int LOSS_THR = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic error,
  input  logic restart,
  output logic loss
);

  localparam int WIN_W = $clog2(LOSS_WIN + 1);
  localparam int THR_W = $clog2(LOSS_THR + 1);

  logic [WIN_W-1:0] win_cnt_q, win_cnt_d, win_next;
  logic [THR_W-1:0] err_cnt_q, err_cnt_d, err_next;

  assign win_next = win_cnt_q + 1'b1;
  assign err_next = err_cnt_q + THR_W'(error);

  always_comb begin
    win_cnt_d = win_cnt_q;
    err_cnt_d = err_cnt_q;
    loss      = 1'b0;
    if (restart) begin
      win_cnt_d = '0;
      err_cnt_d = '0;
    end else if (sample) begin
      // The threshold test comes first so an error on the last sample of a
      // window still counts toward that window.
      if (err_next == THR_W'(LOSS_THR)) begin
        loss      = 1'b1;
        win_cnt_d = '0;
        err_cnt_d = '0;
      end else if (win_next == WIN_W'(LOSS_WIN)) begin
        win_cnt_d = '0;
        err_cnt_d = '0;
      end else begin
        win_cnt_d = win_next;
        err_cnt_d = err_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker with lock/loss detection.
// Define PRBS_CHK_STATS_EN to build the bit/error statistics counters.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int                LENGTH   = 16,
  parameter logic [0:LENGTH-1] TAPS     = PRBS_TAPS_16,
  parameter int                LOCK_CNT = 32,
  parameter int                LOSS_WIN = 64,
  parameter int                LOSS_THR = 8,
  parameter int                CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             din,
  input  logic             clear,
  output logic [1:0]       sync_state,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int FILL_W  = $clog2(LENGTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);

  sync_state_e       state_q, state_d;
  logic [0:LENGTH-1] s_q, s_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic              err_q, err_d;
  logic              exp_bit, s_all_zero;
  logic              lk_sample, lk_mismatch, loss, win_restart;

  assign exp_bit     = ^(TAPS & s_q);
  assign s_all_zero  = (s_q == '0);
  assign lk_sample   = enable && (state_q == LOCKED);
  assign lk_mismatch = lk_sample && (din != exp_bit);
  assign win_restart = (state_q != LOCKED);

  prbs_loss_monitor #(
    .LOSS_WIN (LOSS_WIN),
    .LOSS_THR (LOSS_THR)
  ) u_loss (
    .clk     (clk),
    .rst     (rst),
    .sample  (lk_sample),
    .error   (lk_mismatch),
    .restart (win_restart),
    .loss    (loss)
  );

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    err_d       = 1'b0;
    if (enable) begin
      unique case (state_q)
        FILL: begin
          s_d = {din, s_q[0:LENGTH-2]};
          if (fill_cnt_q == FILL_W'(LENGTH - 1)) begin
            fill_cnt_d = '0;
            state_d    = VERIFY;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
        VERIFY: begin
          s_d = {din, s_q[0:LENGTH-2]};
          // An all-zero register never counts as a match, so an idle line cannot lock.
          if ((din != exp_bit) || s_all_zero) begin
            match_cnt_d = '0;
          end else if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
            match_cnt_d = '0;
            state_d     = LOCKED;
          end else begin
            match_cnt_d = match_cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a line error is not fed back.
          s_d   = {exp_bit, s_q[0:LENGTH-2]};
          err_d = lk_mismatch;
          if (loss) begin
            state_d     = FILL;
            fill_cnt_d  = '0;
            match_cnt_d = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      s_q         <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      err_q       <= err_d;
    end
  end

  assign sync_state = state_q;
  assign locked     = (state_q == LOCKED);
  assign err        = err_q;

`ifdef PRBS_CHK_STATS_EN
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  always_comb begin
    bit_count_d = bit_count_q;
    err_count_d = err_count_q;
    if (clear) begin
      bit_count_d = '0;
      err_count_d = '0;
    end else begin
      if (lk_sample && !(&bit_count_q)) bit_count_d = bit_count_q + 1'b1;
      if (lk_mismatch && !(&err_count_q)) err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_count_q <= '0;
      err_count_q <= '0;
    end else begin
      bit_count_q <= bit_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign bit_count = bit_count_q;
  assign err_count = err_count_q;
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign bit_count    = '0;
  assign err_count    = '0;
`endif

endmodule
